// File: rtl/hdmi_gray_word_packer.sv
// hdmi_gray_word_packer: converts the HDMI-in pixel stream to 8-bit luma, packs four luma
// bytes per 32-bit word and presents each word with its linear frame address on a
// valid/ready interface. Tracks frame boundaries and flags words lost to back-pressure.
// Optional build macro: PACKER_DROP_CNT_EN adds the saturating drop_count output.
module hdmi_gray_word_packer #(
  parameter int unsigned H_RES_PIX      = 640,
  parameter int unsigned V_RES_PIX      = 480,
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned PIX_PER_WORD   = 4,
  parameter int unsigned ADDR_BITS      = 17
) (
  input  logic                               vid_clk,
  input  logic                               reset,
  input  logic [$clog2(H_RES_PIX-1)-1:0]     Hpos,
  input  logic [$clog2(V_RES_PIX-1)-1:0]     Vpos,
  input  logic                               VidEn,
  input  logic [BITS_PER_PIXEL-1:0]          pixel_in,
  input  logic                               line_ready,
  input  logic                               frame_ready,
  output logic [31:0]                        out_data,
  output logic [ADDR_BITS-1:0]               out_addr,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               frame_start,
  output logic                               frame_done,
  output logic                               dropped
`ifdef PACKER_DROP_CNT_EN
  ,
  output logic [15:0]                        drop_count
`endif
);

  localparam int unsigned WordsPerFrame = H_RES_PIX * V_RES_PIX / PIX_PER_WORD;
  localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(WordsPerFrame - 1);

  typedef enum logic [1:0] {StSyncWait, StPacking, StFlush} state_e;

  state_e                r_state;
  logic                  r_frame_done;

  logic                  r_s1_valid;
  logic [7:0]            r_s1_y;
  logic [1:0]            r_s1_lane;
  logic                  r_s1_last;
  logic                  r_s1_origin;

  logic [31:0]           r_pack;
  logic [ADDR_BITS-1:0]  r_addr;

  logic                  r_out_valid;
  logic [31:0]           r_out_data;
  logic [ADDR_BITS-1:0]  r_out_addr;
  logic                  r_frame_start;
  logic                  r_dropped;

  logic                  w_origin;
  logic                  w_accept;
  logic [15:0]           w_sum;
  logic                  w_word_done;
  logic [ADDR_BITS-1:0]  w_word_addr;
  logic [31:0]           w_pack_next;
  logic                  w_can_load;
  logic                  w_load;
  logic                  w_drop;
  logic                  w_start_set;
  logic                  w_last_acc;
  logic                  w_last_drop;
  // Line ends need no action: Hpos/Vpos already place every pixel.
  logic                  w_unused;

  assign w_unused = line_ready;

  assign w_origin = VidEn && (Hpos == '0) && (Vpos == '0);
  assign w_accept = VidEn && ((r_state == StPacking) ||
                              ((r_state == StSyncWait) && w_origin));

  // Weights sum to 256, so the worst case 255*256 = 65280 fits in 16 bits.
  assign w_sum = 16'd77  * {8'd0, pixel_in[23:16]} +
                 16'd150 * {8'd0, pixel_in[15:8]}  +
                 16'd29  * {8'd0, pixel_in[7:0]};

  assign w_word_done = r_s1_valid && r_s1_last;
  // A frame-origin pixel restarts addressing and throws away any partial word.
  assign w_word_addr = r_s1_origin ? '0 : r_addr;
  assign w_can_load  = !r_out_valid || out_ready;
  assign w_load      = w_word_done && w_can_load;
  assign w_drop      = w_word_done && !w_can_load;
  assign w_start_set = w_load && (w_word_addr == '0);
  assign w_last_acc  = r_out_valid && out_ready && (r_out_addr == LastAddr);
  assign w_last_drop = w_drop && (w_word_addr == LastAddr);

  // Merge the stage-1 luma byte into its lane of the pack word.
  always_comb begin
    w_pack_next = r_s1_origin ? 32'd0 : r_pack;
    w_pack_next[{r_s1_lane, 3'b000} +: 8] = r_s1_y;
  end

  // Stage 1: register luma with its lane, last-lane flag and frame-origin flag.
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_y      <= 8'd0;
      r_s1_lane   <= 2'd0;
      r_s1_last   <= 1'b0;
      r_s1_origin <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_y      <= w_sum[15:8];
        r_s1_lane   <= Hpos[1:0];
        r_s1_last   <= (Hpos[1:0] == 2'd3);
        r_s1_origin <= w_origin;
      end
    end
  end

  // Stage 2: pack register and running word-address counter.
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      r_pack <= 32'd0;
      r_addr <= '0;
    end else if (r_s1_valid) begin
      r_pack <= w_pack_next;
      if (w_word_done) begin
        r_addr <= w_word_addr + 1'b1;
      end else if (r_s1_origin) begin
        r_addr <= '0;
      end
    end
  end

  // Single-entry output register; a full register with no accept drops the new word.
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= 32'd0;
      r_out_addr    <= '0;
      r_frame_start <= 1'b0;
      r_dropped     <= 1'b0;
    end else begin
      r_frame_start <= w_start_set;
      r_dropped     <= w_drop;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pack_next;
        r_out_addr  <= w_word_addr;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Frame FSM: wait for origin, pack, then flush until the last word leaves.
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      r_state      <= StSyncWait;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        StSyncWait: begin
          if (w_origin) r_state <= StPacking;
        end
        StPacking: begin
          if (frame_ready) r_state <= StFlush;
        end
        StFlush: begin
          if (w_last_acc || w_last_drop) begin
            r_frame_done <= 1'b1;
            r_state      <= StSyncWait;
          end else if (!r_s1_valid && !r_out_valid) begin
            // Truncated frame: nothing left in flight, so resynchronise quietly.
            r_state <= StSyncWait;
          end
        end
        default: r_state <= StSyncWait;
      endcase
    end
  end

`ifdef PACKER_DROP_CNT_EN
  logic [15:0] r_drop_count;

  // Saturating count of dropped words, restarted with each frame.
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      r_drop_count <= 16'd0;
    end else if (w_start_set) begin
      r_drop_count <= 16'd0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

  assign out_data    = r_out_data;
  assign out_addr    = r_out_addr;
  assign out_valid   = r_out_valid;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign dropped     = r_dropped;

endmodule

// File: tb/tb_hdmi_gray_word_packer.sv
// Directed bench for hdmi_gray_word_packer on a reduced 16x4 frame (16 words).
module tb_hdmi_gray_word_packer;

  localparam int unsigned H = 16;
  localparam int unsigned V = 4;

  logic        vid_clk = 1'b0;
  logic        reset;
  logic [3:0]  Hpos;
  logic [1:0]  Vpos;
  logic        VidEn;
  logic [23:0] pixel_in;
  logic        line_ready;
  logic        frame_ready;
  logic [31:0] out_data;
  logic [7:0]  out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        frame_start;
  logic        frame_done;
  logic        dropped;
`ifdef PACKER_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_fs, n_fd, n_drop, n_words, n_vcyc, exp_addr, last_addr;
  bit mon_en;
  logic [31:0] exp_word [16];
  logic [23:0] prim [4];

  always #5 vid_clk = ~vid_clk;

  hdmi_gray_word_packer #(
    .H_RES_PIX      (H),
    .V_RES_PIX      (V),
    .BITS_PER_PIXEL (24),
    .PIX_PER_WORD   (4),
    .ADDR_BITS      (8)
  ) dut (
    .vid_clk     (vid_clk),
    .reset       (reset),
    .Hpos        (Hpos),
    .Vpos        (Vpos),
    .VidEn       (VidEn),
    .pixel_in    (pixel_in),
    .line_ready  (line_ready),
    .frame_ready (frame_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .dropped     (dropped)
`ifdef PACKER_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] gray(input logic [7:0] g);
    return {g, g, g};
  endfunction

  // Gray level used for generic frame pixels (R=G=B, so luma equals this value).
  function automatic logic [7:0] gv(input int h, input int v);
    return 8'((v * 64) + (h * 4) + 1);
  endfunction

  task automatic mon();
    if (frame_start) n_fs++;
    if (frame_done) n_fd++;
    if (dropped) n_drop++;
    if (out_valid) n_vcyc++;
    if (mon_en && out_valid && out_ready) begin
      check("word_addr", 32'(out_addr), 32'(exp_addr));
      check("word_data", out_data, exp_word[4'(exp_addr)]);
      last_addr = int'(out_addr);
      exp_addr++;
      n_words++;
    end
  endtask

  task automatic tick();
    @(posedge vid_clk);
    #1;
    mon();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input int h, input int v, input logic [23:0] pix, input bit fr);
    VidEn       = 1'b1;
    Hpos        = 4'(h);
    Vpos        = 2'(v);
    pixel_in    = pix;
    line_ready  = (h == 15);
    frame_ready = fr;
    tick();
    VidEn       = 1'b0;
    line_ready  = 1'b0;
    frame_ready = 1'b0;
  endtask

  initial begin
    logic [23:0] pix;
    reset = 1'b1;
    VidEn = 1'b0;
    Hpos = 4'd0;
    Vpos = 2'd0;
    pixel_in = 24'd0;
    line_ready = 1'b0;
    frame_ready = 1'b0;
    out_ready = 1'b1;
    mon_en = 1'b0;
    n_fs = 0; n_fd = 0; n_drop = 0; n_words = 0; n_vcyc = 0; exp_addr = 0; last_addr = -1;
    prim[0] = 24'hFFFFFF;
    prim[1] = 24'hFF0000;
    prim[2] = 24'h00FF00;
    prim[3] = 24'h0000FF;
    for (int w = 0; w < 16; w++) begin
      exp_word[w] = {gv((w % 4) * 4 + 3, w / 4), gv((w % 4) * 4 + 2, w / 4),
                     gv((w % 4) * 4 + 1, w / 4), gv((w % 4) * 4, w / 4)};
    end
    exp_word[0] = 32'h40302010;
    // Luma of FFFFFF, FF0000, 00FF00, 0000FF: FF, 4C, 95, 1C in lanes 0..3.
    exp_word[1] = 32'h1C954CFF;

    // Reset state.
    repeat (3) @(posedge vid_clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_fstart", 32'(frame_start), 32'd0);
    check("rst_fdone", 32'(frame_done), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
`ifdef PACKER_DROP_CNT_EN
    check("rst_dcnt", 32'(drop_count), 32'd0);
`endif
    reset = 1'b0;

    // Stream joins mid-frame: nothing may be emitted before the origin.
    n_vcyc = 0;
    for (int v = 2; v < 4; v++)
      for (int h = 0; h < 16; h++) drive(h, v, gray(8'h77), 1'b0);
    idle(3);
    check("sync_quiet", 32'(n_vcyc), 32'd0);

    // Full frame with continuous ready, including gray-math and latency vectors.
    n_fs = 0; n_fd = 0; n_drop = 0; n_words = 0; exp_addr = 0; mon_en = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 16; h++) begin
        if (v == 0 && h < 4) pix = gray(8'((h + 1) * 16));
        else if (v == 0 && h < 8) pix = prim[h - 4];
        else pix = gray(gv(h, v));
        drive(h, v, pix, (v == 3) && (h == 15));
        if (v == 0 && h == 3) check("lat_early", 32'(out_valid), 32'd0);
        if (v == 0 && h == 4) begin
          check("lat_valid", 32'(out_valid), 32'd1);
          check("lat_data", out_data, 32'h40302010);
          check("lat_addr", 32'(out_addr), 32'd0);
          check("lat_fstart", 32'(frame_start), 32'd1);
        end
      end
    end
    idle(4);
    check("ff_words", 32'(n_words), 32'd16);
    check("ff_last_addr", 32'(last_addr), 32'd15);
    check("ff_fdone", 32'(n_fd), 32'd1);
    check("ff_no_drop", 32'(n_drop), 32'd0);
    check("ff_fstart", 32'(n_fs), 32'd1);

    // Back-pressure across two completed words.
    mon_en = 1'b0;
    out_ready = 1'b0;
    n_drop = 0;
    for (int h = 0; h < 8; h++) drive(h, 0, gray(8'(8'hA0 + h)), 1'b0);
    idle(1);
    check("bp_drop", 32'(dropped), 32'd1);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_addr", 32'(out_addr), 32'd0);
    check("bp_data", out_data, 32'hA3A2A1A0);
`ifdef PACKER_DROP_CNT_EN
    check("bp_dcnt", 32'(drop_count), 32'd1);
`endif
    idle(1);
    check("bp_pulse", 32'(dropped), 32'd0);
    check("bp_hold", out_data, 32'hA3A2A1A0);
    check("bp_ndrop", 32'(n_drop), 32'd1);
    out_ready = 1'b1;
    idle(1);
    check("bp_accept", 32'(out_valid), 32'd0);
    for (int h = 8; h < 12; h++) drive(h, 0, gray(8'(8'hA0 + h)), 1'b0);
    idle(1);
    check("bp_nvalid", 32'(out_valid), 32'd1);
    check("bp_naddr", 32'(out_addr), 32'd2);
    check("bp_ndata", out_data, 32'hABAAA9A8);

    // Reset while a word is held: out_valid must fall without a clock edge.
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_addr", 32'(out_addr), 32'd0);
    @(posedge vid_clk);
    #1;
    reset = 1'b0;
    n_vcyc = 0;
    for (int h = 0; h < 16; h++) drive(h, 1, gray(8'h33), 1'b0);
    for (int h = 0; h < 4; h++) drive(h, 2, gray(8'h33), 1'b0);
    idle(2);
    check("arst_quiet", 32'(n_vcyc), 32'd0);
    for (int h = 0; h < 4; h++) drive(h, 0, gray(8'(8'h50 + h)), 1'b0);
    idle(1);
    check("arst_ovalid", 32'(out_valid), 32'd1);
    check("arst_oaddr", 32'(out_addr), 32'd0);
    check("arst_odata", out_data, 32'h53525150);
    check("arst_fstart", 32'(frame_start), 32'd1);

    // Gaps in VidEn within a word.
    drive(4, 0, gray(8'h54), 1'b0);
    idle(2);
    drive(5, 0, gray(8'h55), 1'b0);
    drive(6, 0, gray(8'h56), 1'b0);
    idle(1);
    drive(7, 0, gray(8'h57), 1'b0);
    idle(1);
    check("gap_valid", 32'(out_valid), 32'd1);
    check("gap_addr", 32'(out_addr), 32'd1);
    check("gap_data", out_data, 32'h57565554);

    // Origin seen while packing restarts the frame with no drop.
    n_drop = 0;
    n_fs = 0;
    drive(8, 0, gray(8'h58), 1'b0);
    drive(9, 0, gray(8'h59), 1'b0);
    for (int h = 0; h < 4; h++) drive(h, 0, gray(8'(8'h60 + h)), 1'b0);
    idle(1);
    check("rs_addr", 32'(out_addr), 32'd0);
    check("rs_data", out_data, 32'h63626160);
    check("rs_fstart", 32'(frame_start), 32'd1);
    idle(2);
    check("rs_no_drop", 32'(n_drop), 32'd0);
    check("rs_fs_once", 32'(n_fs), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
